// File: rtl/decode_pkg.sv
// Shared opcode, branch-select and function-select codes plus the stage state type
// for the 16-bit teaching CPU decode stage.
package decode_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LB    = 4'b0010;
    localparam logic [3:0] OP_SB    = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ANDI  = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_BGEZ  = 4'b1010;
    localparam logic [3:0] OP_JR    = 4'b1011;
    localparam logic [3:0] OP_RTYPE = 4'b1111;

    localparam logic [2:0] BS_EQ   = 3'b000;
    localparam logic [2:0] BS_NE   = 3'b001;
    localparam logic [2:0] BS_GEZ  = 3'b010;
    localparam logic [2:0] BS_JR   = 3'b011;
    localparam logic [2:0] BS_NONE = 3'b100;

    localparam logic [2:0] FS_ADD  = 3'b000;
    localparam logic [2:0] FS_HALT = 3'b001;
    localparam logic [2:0] FS_BGEZ = 3'b010;
    localparam logic [2:0] FS_AND  = 3'b101;
    localparam logic [2:0] FS_OR   = 3'b110;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_HALTED = 2'b10
    } stage_state_e;

endpackage

// File: rtl/decode_stage_pipe_inst_field_decode.sv
// Combinational instruction-to-control-word decoder with source-register usage flags.
// Define DECODE_ILLEGAL_TRAP_EN to add the illegal output for undefined encodings.
module inst_field_decode
    import decode_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int INST_W = 16,
    parameter int IMM_W  = INST_W - 4 - 2 * REG_W
) (
    input  logic [INST_W-1:0] inst,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  sa,
    output logic [REG_W-1:0]  sb,
    output logic [IMM_W-1:0]  imm,
    output logic [IMM_W-1:0]  off,
    output logic              mb,
    output logic              md,
    output logic              ld,
    output logic              mw,
    output logic              halt,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic [2:0]        fs,
    output logic [2:0]        bs,
    output logic              uses_sa,
    output logic              uses_sb
);

    logic [3:0]       op_s;
    logic [REG_W-1:0] rs_s;
    logic [REG_W-1:0] rt_s;
    logic [REG_W-1:0] rd_s;
    logic [2:0]       funct_s;
    logic [IMM_W-1:0] imm_field_s;

    assign op_s        = inst[INST_W-1 -: 4];
    assign rs_s        = inst[INST_W-5 -: REG_W];
    assign rt_s        = inst[INST_W-5-REG_W -: REG_W];
    assign rd_s        = inst[INST_W-5-2*REG_W -: REG_W];
    assign funct_s     = inst[2:0];
    assign imm_field_s = inst[IMM_W-1:0];

    // Opcode decode; every field not driven by an opcode stays zero, BS stays "no branch".
    always_comb begin
        dr      = {REG_W{1'b0}};
        imm     = {IMM_W{1'b0}};
        off     = {IMM_W{1'b0}};
        mb      = 1'b0;
        md      = 1'b0;
        ld      = 1'b0;
        mw      = 1'b0;
        halt    = 1'b0;
        fs      = FS_ADD;
        bs      = BS_NONE;
        uses_sa = 1'b0;
        uses_sb = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal = 1'b0;
`endif
        case (op_s)
            OP_NOP: begin
                if (funct_s != 3'b000) begin
                    halt = 1'b1;
                    fs   = FS_HALT;
`ifdef DECODE_ILLEGAL_TRAP_EN
                    illegal = (funct_s != 3'b001);
`endif
                end else begin
                    bs = BS_NONE;
                end
            end
            OP_LB: begin
                dr      = rt_s;
                mb      = 1'b1;
                md      = 1'b1;
                ld      = 1'b1;
                imm     = imm_field_s;
                uses_sa = 1'b1;
            end
            OP_SB: begin
                mb      = 1'b1;
                mw      = 1'b1;
                imm     = imm_field_s;
                uses_sa = 1'b1;
                uses_sb = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                dr      = rt_s;
                mb      = 1'b1;
                ld      = 1'b1;
                imm     = imm_field_s;
                uses_sa = 1'b1;
                case (op_s)
                    OP_ANDI: fs = FS_AND;
                    OP_ORI:  fs = FS_OR;
                    default: fs = FS_ADD;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                fs      = FS_OR;
                off     = imm_field_s;
                bs      = (op_s == OP_BNE) ? BS_NE : BS_EQ;
                uses_sa = 1'b1;
                uses_sb = 1'b1;
            end
            OP_BGEZ: begin
                mb      = 1'b1;
                fs      = FS_BGEZ;
                bs      = BS_GEZ;
                off     = imm_field_s;
                uses_sa = 1'b1;
            end
            OP_JR: begin
                fs      = funct_s;
                md      = 1'b1;
                bs      = BS_JR;
                off     = imm_field_s;
                uses_sa = 1'b1;
            end
            OP_RTYPE: begin
                dr      = rd_s;
                fs      = funct_s;
                ld      = 1'b1;
                uses_sa = 1'b1;
                uses_sb = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
                bs = BS_NONE;
            end
        endcase
        sa = uses_sa ? rs_s : {REG_W{1'b0}};
        sb = uses_sb ? rt_s : {REG_W{1'b0}};
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: valid/ready handshake, load-use stall, branch flush, sticky HALT.
// Define DECODE_ILLEGAL_TRAP_EN to add the ILLEGAL output and trap undefined encodings.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int INST_W = 16,
    parameter int IMM_W  = INST_W - 4 - 2 * REG_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [INST_W-1:0] INST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              OUT_READY,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    output logic [REG_W-1:0]  DR,
    output logic [REG_W-1:0]  SA,
    output logic [REG_W-1:0]  SB,
    output logic [IMM_W-1:0]  IMM,
    output logic [IMM_W-1:0]  OFF,
    output logic              MB,
    output logic              MD,
    output logic              LD,
    output logic              MW,
    output logic              HALT,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic              ILLEGAL,
`endif
    output logic [2:0]        FS,
    output logic [2:0]        BS
);

    stage_state_e     state_r;
    stage_state_e     state_next_s;
    logic             out_valid_r;
    logic [REG_W-1:0] dr_r, sa_r, sb_r;
    logic [IMM_W-1:0] imm_r, off_r;
    logic             mb_r, md_r, ld_r, mw_r, halt_r;
    logic [2:0]       fs_r, bs_r;

    logic [REG_W-1:0] dec_dr_s, dec_sa_s, dec_sb_s;
    logic [IMM_W-1:0] dec_imm_s, dec_off_s;
    logic             dec_mb_s, dec_md_s, dec_ld_s, dec_mw_s, dec_halt_s;
    logic [2:0]       dec_fs_s, dec_bs_s;
    logic             uses_sa_s, uses_sb_s;
    logic             hazard_s, in_ready_s, accept_s, xfer_s, load_s, stops_s;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic dec_illegal_s;
    logic illegal_r;
`endif

    inst_field_decode #(
        .REG_W  (REG_W),
        .INST_W (INST_W),
        .IMM_W  (IMM_W)
    ) u_field_decode (
        .inst    (INST),
        .dr      (dec_dr_s),
        .sa      (dec_sa_s),
        .sb      (dec_sb_s),
        .imm     (dec_imm_s),
        .off     (dec_off_s),
        .mb      (dec_mb_s),
        .md      (dec_md_s),
        .ld      (dec_ld_s),
        .mw      (dec_mw_s),
        .halt    (dec_halt_s),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal (dec_illegal_s),
`endif
        .fs      (dec_fs_s),
        .bs      (dec_bs_s),
        .uses_sa (uses_sa_s),
        .uses_sb (uses_sb_s)
    );

    // A held load whose result the incoming instruction reads; r0 is hardwired and never hazards.
    assign hazard_s = out_valid_r && md_r && ld_r && (dr_r != {REG_W{1'b0}}) &&
                      ((uses_sa_s && (dec_sa_s == dr_r)) || (uses_sb_s && (dec_sb_s == dr_r)));

    assign in_ready_s = !RESET && (state_r == ST_RUN) && (!out_valid_r || OUT_READY) && !hazard_s;
    assign accept_s   = IN_VALID && in_ready_s;
    assign xfer_s     = out_valid_r && OUT_READY;
    assign load_s     = accept_s && !FLUSH;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign stops_s = dec_halt_s || dec_illegal_s;
`else
    assign stops_s = dec_halt_s;
`endif

    // Next-state logic: halt is sticky until reset, stall lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (load_s && stops_s) begin
                    state_next_s = ST_HALTED;
                end else if (hazard_s && xfer_s && !FLUSH) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALL:  state_next_s = ST_RUN;
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Stage state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output valid: set on a surviving accept, cleared by flush or a completed transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
        end else if (FLUSH || xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Control-word register: loads only on an accept that is not flushed, otherwise holds.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dr_r   <= {REG_W{1'b0}};
            sa_r   <= {REG_W{1'b0}};
            sb_r   <= {REG_W{1'b0}};
            imm_r  <= {IMM_W{1'b0}};
            off_r  <= {IMM_W{1'b0}};
            mb_r   <= 1'b0;
            md_r   <= 1'b0;
            ld_r   <= 1'b0;
            mw_r   <= 1'b0;
            halt_r <= 1'b0;
            fs_r   <= FS_ADD;
            bs_r   <= BS_NONE;
        end else if (load_s) begin
            dr_r   <= dec_dr_s;
            sa_r   <= dec_sa_s;
            sb_r   <= dec_sb_s;
            imm_r  <= dec_imm_s;
            off_r  <= dec_off_s;
            mb_r   <= dec_mb_s;
            md_r   <= dec_md_s;
            ld_r   <= dec_ld_s;
            mw_r   <= dec_mw_s;
            halt_r <= dec_halt_s;
            fs_r   <= dec_fs_s;
            bs_r   <= dec_bs_s;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Illegal flag travels with the rest of the control word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            illegal_r <= 1'b0;
        end else if (load_s) begin
            illegal_r <= dec_illegal_s;
        end
    end

    assign ILLEGAL = illegal_r;
`endif

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_r;
    assign DR        = dr_r;
    assign SA        = sa_r;
    assign SB        = sb_r;
    assign IMM       = imm_r;
    assign OFF       = off_r;
    assign MB        = mb_r;
    assign MD        = md_r;
    assign LD        = ld_r;
    assign MW        = mw_r;
    assign HALT      = halt_r;
    assign FS        = fs_r;
    assign BS        = bs_r;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed vector table, then random traffic against a reference model.
module tb_decode_stage_pipe;

    typedef struct packed {
        logic [2:0] dr;
        logic [2:0] sa;
        logic [2:0] sb;
        logic [5:0] imm;
        logic [5:0] off;
        logic       mb;
        logic       md;
        logic       ld;
        logic       mw;
        logic       halt;
        logic [2:0] fs;
        logic [2:0] bs;
    } bnd_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        ordy;
        logic        fl;
        logic [15:0] i;
        logic        e_rdy;
        logic        e_ov;
        bnd_t        e_b;
    } vec_t;

    typedef struct {
        bnd_t b;
        bit   usa;
        bit   usb;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [15:0] inst;
    logic        in_ready, out_valid;
    logic [2:0]  dr, sa, sb, fs, bs;
    logic [5:0]  imm, off;
    logic        mb, md, ld, mw, halt;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    bnd_t        act;

    int vectors = 0;
    int fails   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .CLK       (clk),
        .RESET     (reset),
        .INST      (inst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_READY (out_ready),
        .FLUSH     (flush),
        .OUT_VALID (out_valid),
        .DR        (dr),
        .SA        (sa),
        .SB        (sb),
        .IMM       (imm),
        .OFF       (off),
        .MB        (mb),
        .MD        (md),
        .LD        (ld),
        .MW        (mw),
        .HALT      (halt),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .ILLEGAL   (illegal),
`endif
        .FS        (fs),
        .BS        (bs)
    );

    assign act = {dr, sa, sb, imm, off, mb, md, ld, mw, halt, fs, bs};

    function automatic bnd_t mk(input int d, input int a, input int b, input int im, input int of,
                                input int m_b, input int m_d, input int l, input int w, input int h,
                                input int f, input int s);
        bnd_t r;
        r.dr = 3'(d);   r.sa = 3'(a);   r.sb = 3'(b);
        r.imm = 6'(im); r.off = 6'(of);
        r.mb = 1'(m_b); r.md = 1'(m_d); r.ld = 1'(l); r.mw = 1'(w); r.halt = 1'(h);
        r.fs = 3'(f);   r.bs = 3'(s);
        return r;
    endfunction

    // Reference decoder written directly from the opcode table.
    function automatic dec_t ref_dec(input logic [15:0] i);
        dec_t d;
        int op, rs, rt, rd, fn, im;
        op = int'(i) / 4096;
        rs = (int'(i) / 512) % 8;
        rt = (int'(i) / 64) % 8;
        rd = (int'(i) / 8) % 8;
        fn = int'(i) % 8;
        im = int'(i) % 64;
        d.b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        d.usa = (op == 2) || (op >= 4 && op <= 11) || (op == 15);
        d.usb = (op == 4) || (op == 8) || (op == 9) || (op == 15);
        case (op)
            0:  if (fn != 0) d.b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
            2:  d.b = mk(rt, 0, 0, im, 0, 1, 1, 1, 0, 0, 0, 4);
            4:  d.b = mk(0, 0, 0, im, 0, 1, 0, 0, 1, 0, 0, 4);
            5:  d.b = mk(rt, 0, 0, im, 0, 1, 0, 1, 0, 0, 0, 4);
            6:  d.b = mk(rt, 0, 0, im, 0, 1, 0, 1, 0, 0, 5, 4);
            7:  d.b = mk(rt, 0, 0, im, 0, 1, 0, 1, 0, 0, 6, 4);
            8:  d.b = mk(0, 0, 0, 0, im, 0, 0, 0, 0, 0, 6, 0);
            9:  d.b = mk(0, 0, 0, 0, im, 0, 0, 0, 0, 0, 6, 1);
            10: d.b = mk(0, 0, 0, 0, im, 1, 0, 0, 0, 0, 2, 2);
            11: d.b = mk(0, 0, 0, 0, im, 0, 1, 0, 0, 0, fn, 3);
            15: d.b = mk(rd, 0, 0, 0, 0, 0, 0, 1, 0, 0, fn, 4);
            default: d.b.bs = 3'd4;
        endcase
        if (d.usa) d.b.sa = 3'(rs);
        if (d.usb) d.b.sb = 3'(rt);
        return d;
    endfunction

    task automatic check_bit(input string nm, input logic a, input logic e);
        vectors++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic check_bnd(input string nm, input bnd_t a, input bnd_t e);
        vectors++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got bundle %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic add(input int rst, input int vld, input int ordy, input int fl, input logic [15:0] i,
                       input int e_rdy, input int e_ov, input bnd_t e_b);
        vec_t v;
        v.rst = (rst != 0); v.vld = (vld != 0); v.ordy = (ordy != 0); v.fl = (fl != 0);
        v.i = i; v.e_rdy = (e_rdy != 0); v.e_ov = (e_ov != 0); v.e_b = e_b;
        tbl.push_back(v);
    endtask

    initial begin
        bnd_t rst_b, addi_b, lb4_b, rt4_b, lb0_b, rt0_b, andi_b, beq_b, halt_b;
        logic [15:0] addi_i, lb4_i, rt4_i, lb0_i, rt0_i, andi_i, beq_i, ori_i;
        bit   m_valid, m_halted, m_stall;
        bnd_t m_b;

        rst_b  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        addi_b = mk(3, 2, 0, 5, 0, 1, 0, 1, 0, 0, 0, 4);
        lb4_b  = mk(4, 1, 0, 2, 0, 1, 1, 1, 0, 0, 0, 4);
        rt4_b  = mk(5, 2, 4, 0, 0, 0, 0, 1, 0, 0, 1, 4);
        lb0_b  = mk(0, 1, 0, 2, 0, 1, 1, 1, 0, 0, 0, 4);
        rt0_b  = mk(5, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4);
        andi_b = mk(1, 7, 0, 63, 0, 1, 0, 1, 0, 0, 5, 4);
        beq_b  = mk(0, 3, 5, 0, 42, 0, 0, 0, 0, 0, 6, 0);
        halt_b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        addi_i = 16'h54C5; lb4_i = 16'h2302; rt4_i = 16'hF529; lb0_i = 16'h2202;
        rt0_i  = 16'hF429; andi_i = 16'h6E7F; beq_i = 16'h876A; ori_i = 16'h7589;

        //   rst vld rdy fl inst        e_rdy e_ov bundle
        add(1, 0, 1, 0, 16'h0000, 0, 0, rst_b);
        add(0, 1, 1, 0, addi_i,   1, 0, rst_b);
        add(0, 0, 1, 0, 16'h0000, 1, 1, addi_b);
        add(0, 1, 1, 0, lb4_i,    1, 0, addi_b);
        add(0, 1, 1, 0, rt4_i,    0, 1, lb4_b);
        add(0, 1, 1, 0, rt4_i,    0, 0, lb4_b);
        add(0, 1, 1, 0, rt4_i,    1, 0, lb4_b);
        add(0, 0, 1, 0, 16'h0000, 1, 1, rt4_b);
        add(0, 1, 1, 0, lb0_i,    1, 0, rt4_b);
        add(0, 1, 1, 0, rt0_i,    1, 1, lb0_b);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, andi_i, 0, 1, rt0_b);
        add(0, 1, 1, 0, andi_i,   1, 1, rt0_b);
        add(0, 0, 1, 0, 16'h0000, 1, 1, andi_b);
        add(0, 1, 1, 0, beq_i,    1, 0, andi_b);
        add(0, 1, 1, 1, ori_i,    1, 1, beq_b);
        add(0, 0, 1, 0, 16'h0000, 1, 0, beq_b);
        add(0, 0, 1, 0, 16'h0000, 1, 0, beq_b);
        add(0, 1, 1, 0, 16'h0001, 1, 0, beq_b);
        add(0, 1, 1, 0, addi_i,   0, 1, halt_b);
        for (int k = 0; k < 10; k++) add(0, 1, 1, (k == 4) ? 1 : 0, addi_i, 0, 0, halt_b);
        add(1, 1, 1, 0, addi_i,   0, 0, halt_b);
        add(0, 0, 1, 0, 16'h0000, 1, 0, rst_b);
        add(0, 1, 1, 0, 16'h3123, 1, 0, rst_b);
        add(0, 0, 1, 0, 16'h0000, 1, 1, rst_b);
        add(0, 1, 1, 1, 16'h0001, 1, 0, rst_b);
        add(0, 1, 1, 0, addi_i,   1, 0, rst_b);
        add(0, 0, 1, 0, 16'h0000, 1, 1, addi_b);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; inst = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            reset = tbl[n].rst; in_valid = tbl[n].vld; out_ready = tbl[n].ordy;
            flush = tbl[n].fl;  inst = tbl[n].i;
            @(negedge clk);
            check_bit($sformatf("dir%0d_in_ready", n), in_ready, tbl[n].e_rdy);
            check_bit($sformatf("dir%0d_out_valid", n), out_valid, tbl[n].e_ov);
            check_bnd($sformatf("dir%0d_bundle", n), act, tbl[n].e_b);
            @(posedge clk);
            #1;
        end

        // Random traffic against the reference model, starting from reset.
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_halted = 1'b0; m_stall = 1'b0; m_b = rst_b;
        for (int c = 0; c < 3000; c++) begin
            dec_t d;
            bit   hz, e_rdy, acc, xfer, nstall;
            int   op_pick;
            logic [3:0] op;
            logic [5:0] low;
            op_pick = int'($urandom_range(0, 15));
            case (op_pick)
                0, 1, 2: op = 4'h2;
                3, 4:    op = 4'hF;
                5:       op = 4'h0;
                6:       op = 4'h3;
                default: op = 4'(op_pick - 3);
            endcase
            low = 6'($urandom_range(0, 63));
            if (op == 4'h0 && $urandom_range(0, 7) != 0) low[2:0] = 3'b000;
            inst      = {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), low};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 49) == 0);

            d     = ref_dec(inst);
            hz    = m_valid && m_b.md && m_b.ld && (m_b.dr != 3'd0) &&
                    ((d.usa && d.b.sa == m_b.dr) || (d.usb && d.b.sb == m_b.dr));
            e_rdy = !reset && !m_halted && !m_stall && (!m_valid || out_ready) && !hz;

            @(negedge clk);
            check_bit($sformatf("rnd%0d_in_ready", c), in_ready, e_rdy);
            check_bit($sformatf("rnd%0d_out_valid", c), out_valid, m_valid);
            check_bnd($sformatf("rnd%0d_bundle", c), act, m_b);

            acc  = in_valid && e_rdy;
            xfer = m_valid && out_ready;
            if (reset) begin
                m_valid = 1'b0; m_halted = 1'b0; m_stall = 1'b0; m_b = rst_b;
            end else begin
                nstall = !m_halted && !m_stall && hz && xfer && !flush;
                if (acc && !flush) begin
                    m_b = d.b;
                    m_valid = 1'b1;
                    if (d.b.halt) m_halted = 1'b1;
                end else if (flush || xfer) begin
                    m_valid = 1'b0;
                end
                m_stall = nstall;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Registered, parametrised instruction-decode pipeline stage for the 16-bit teaching CPU.
- Sits between fetch and the datapath/register file.
- Accepts one instruction per cycle over a valid/ready handshake and produces the full control-word bundle (DR/SA/SB/IMM/MB/FS/MD/LD/MW/BS/OFF/HALT) one cycle later.
- Adds what a purely combinational decoder lacks: load-use hazard stalling, branch flush, and a sticky HALT state.

Parameters:
- REG_W, 3, register-address width. Sets the width of the RS/RT/RD fields.
- INST_W, 16, instruction width. Must equal 7+3*REG_W.
- IMM_W, INST_W-4-2*REG_W (6), immediate/offset width. Taken from INST[IMM_W-1:0].

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- INST  in  INST_W  instruction. Fields: OP=[top 4], RS, RT, RD (REG_W each, high to low), FUNCT=[2:0].
- IN_VALID  in  1  INST is valid.
- IN_READY  out  1  stage accepts INST this cycle.
- OUT_READY  in  1  downstream accepts the bundle.
- FLUSH  in  1  taken branch: kill the held bundle and discard any instruction accepted this cycle.
- OUT_VALID  out  1  bundle is valid.
- DR, SA, SB  out  REG_W each  destination and source register addresses.
- IMM  out  IMM_W  immediate value.
- OFF  out  IMM_W  branch offset.
- MB, MD, LD, MW, HALT  out  1 each  control bits.
- FS, BS  out  3 each  function select and branch select.
- ILLEGAL  out  1  only present with ILLEGAL_TRAP_EN.

Behaviour:
- Handshake
  - IN accept = IN_VALID && IN_READY.
  - OUT transfer = OUT_VALID && OUT_READY.
  - IN_READY = (state==RUN) && (!OUT_VALID || OUT_READY) && !hazard. IN_READY is combinational and does not depend on IN_VALID.
- Latency and output hold
  - On accept, the decoded bundle is registered and OUT_VALID=1 on the next cycle (latency 1).
  - Outputs hold stable while OUT_VALID && !OUT_READY.
  - Outputs update only on accept.
- Opcode decode (unused fields = 0)
  - 0000: FUNCT==0 is NOP (BS=100). FUNCT!=0 is HALT (HALT=1, FS=001).
  - 0010 LB: DR=RT, MB=1, MD=1, LD=1, IMM.
  - 0100 SB: SA=RS, SB=RT, MB=1, MW=1, IMM.
  - 0101 ADDI: FS=000. 0110 ANDI: FS=101. 0111 ORI: FS=110. All three: DR=RT, MB=1, LD=1, IMM.
  - 1000 BEQ: BS=000. 1001 BNE: BS=001. Both: SA=RS, SB=RT, FS=110, OFF=IMM field.
  - 1010 BGEZ: MB=1, FS=010, BS=010, OFF=IMM field.
  - 1011 JR: FS=FUNCT, MD=1, BS=011, OFF=IMM field.
  - 1111 R-type: DR=RD, SA=RS, SB=RT, FS=FUNCT, LD=1.
  - Other opcodes: NOP (BS=100).
- Source usage
  - SA is used by all opcodes except NOP, HALT and undefined.
  - SB is used only by SB, BEQ, BNE and R-type.
- Load-use hazard
  - Condition: the held bundle is valid with MD=1 && LD=1, its DR!=0, and INST uses that register as SA or SB.
  - When the held load transfers with the hazard present, the stage goes to STALL for 1 cycle: IN_READY=0, OUT_VALID=0.
  - STALL then returns to RUN.
  - Register 0 never hazards.
- States
  - RESET → RUN.
  - RUN → STALL: on the hazard condition above.
  - STALL → RUN: after 1 cycle.
  - RUN → HALTED: when a HALT instruction is accepted. The HALT bundle is still presented downstream once.
  - HALTED: IN_READY=0 and stays 0 until RESET. FLUSH does not leave HALTED.
- FLUSH
  - Next cycle OUT_VALID=0.
  - An instruction accepted in the same cycle is discarded; upstream still sees it as consumed.
  - STALL → RUN.
  - A flushed HALT does not enter HALTED.
- Reset
  - All outputs 0 except BS=100.
  - OUT_VALID=0, state=RUN.
  - Reset mid-stall or mid-hold discards everything.
  - IN_READY=0 during the RESET cycle.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: undefined opcodes and 0000 with FUNCT in 2..7 set ILLEGAL=1 in the bundle and move the stage to HALTED, exactly as HALT does.
- Undefined: no ILLEGAL port, and undefined opcodes decode as NOP.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_NOP, OP_LB, OP_SB, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_BGEZ, OP_JR, OP_RTYPE);
  - BS codes (BS_EQ, BS_NE, BS_GEZ, BS_JR, BS_NONE=100);
  - FS codes;
  - the stage-state enum.
- One natural sub-module: inst_field_decode. It is purely combinational, maps INST to the control bundle plus uses_sa/uses_sb, and is parametrised identically.
- Hazard logic, state machine and output register stay in the top level.

Test Plan:
- Reset, then ADDI 0x5_2_3_05 (RS=2, RT=3, IMM=5) with OUT_READY=1 → 1 cycle later OUT_VALID=1, DR=3, SA=2, MB=1, LD=1, FS=000, IMM=5, BS=100.
- LB into r4, then R-type reading r4 as SB → bubble cycle with OUT_VALID=0 and IN_READY=0, then the R-type is presented. Repeat with LB into r0 → no bubble.
- OUT_READY=0 for 3 cycles with IN_VALID=1 → IN_READY=0 and outputs stable. When OUT_READY rises, the next instruction is accepted back-to-back.
- BEQ held and FLUSH asserted while ORI is accepted → next cycle OUT_VALID=0 and the ORI never appears.
- HALT (0x0001) accepted → bundle with HALT=1 and FS=001 presented once, then IN_READY stays 0 for ≥10 cycles. RESET returns IN_READY=1.
- With DECODE_ILLEGAL_TRAP_EN, opcode 0011 → ILLEGAL=1 and stage HALTED. Without it → NOP bundle (BS=100, LD=0, MW=0).
